store_alignment_unit: RTL and testbench

Store-path counterpart of the load-alignment logic in the kianv rv32ima core. Takes a store request (op, byte address, rs2 data) and produces word-aligned memory write transactions with per-lane strobes and lane-shifted data. Misaligned stores either raise a fault pulse or, when configured, split into two aligned word writes. Sits between the multicycle control FSM and the memory/bus interface.

---
 rtl/store_alignment_unit_pkg.sv | 41 ++++
 rtl/store_alignment_unit_lane_shift.sv | 39 +++
 rtl/store_alignment_unit.sv | 189 ++++++++++++++++++
 tb/tb_store_alignment_unit.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_alignment_unit_pkg.sv
// Store-op encodings, FSM state type and store-size helpers shared by the store path.
// The optional split-store behaviour is selected by defining RV_STORE_SPLIT_EN.
`ifndef STORE_OP_WIDTH
`define STORE_OP_WIDTH 2
`endif
`ifndef STORE_OP_SB
`define STORE_OP_SB 2'd0
`endif
`ifndef STORE_OP_SH
`define STORE_OP_SH 2'd1
`endif
`ifndef STORE_OP_SW
`define STORE_OP_SW 2'd2
`endif

package store_alignment_unit_pkg;

    localparam int unsigned OP_W = `STORE_OP_WIDTH;

    typedef logic [OP_W-1:0] store_op_t;

    localparam store_op_t OP_SB = `STORE_OP_SB;
    localparam store_op_t OP_SH = `STORE_OP_SH;
    localparam store_op_t OP_SW = `STORE_OP_SW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_ISSUE2 = 2'd2
    } state_e;

    function automatic logic op_known(input store_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Architectural alignment rule: halfwords need an even address, words a multiple of four.
    function automatic logic op_misaligned(input store_op_t op, input logic [1:0] off);
        return ((op == OP_SH) && off[0]) || ((op == OP_SW) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_alignment_unit_lane_shift.sv
// store_lane_shift: positions store data and byte strobes across an 8-lane (two-word) window.
// Lanes 7:4 are non-zero only when the store crosses into the next word.
module store_lane_shift
    import store_alignment_unit_pkg::*;
(
    input  logic [`STORE_OP_WIDTH-1:0] op_i,
    input  logic [1:0]                 off_i,
    input  logic [31:0]                data_i,
    output logic [7:0]                 strb_o,
    output logic [63:0]                wdata_o
);

    logic [3:0]  base_strb;
    logic [31:0] masked_data;

    always_comb begin
        base_strb   = 4'b0000;
        masked_data = 32'h0000_0000;
        case (op_i)
            OP_SB: begin
                base_strb   = 4'b0001;
                masked_data = {24'h00_0000, data_i[7:0]};
            end
            OP_SH: begin
                base_strb   = 4'b0011;
                masked_data = {16'h0000, data_i[15:0]};
            end
            OP_SW: begin
                base_strb   = 4'b1111;
                masked_data = data_i;
            end
            default: ;
        endcase
    end

    assign strb_o  = {4'b0000, base_strb} << off_i;
    assign wdata_o = {32'h0000_0000, masked_data} << {off_i, 3'b000};

endmodule

// File: rtl/store_alignment_unit.sv
// store_alignment_unit: turns SB/SH/SW requests into word-aligned strobed memory writes.
// Define RV_STORE_SPLIT_EN to split word-crossing stores into two writes instead of faulting.
module store_alignment_unit
    import store_alignment_unit_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [`STORE_OP_WIDTH-1:0] req_op,
    input  logic [31:0]                req_addr,
    input  logic [31:0]                req_data,
    output logic                       mem_valid,
    input  logic                       mem_ready,
    output logic [31:0]                mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [3:0]                 mem_wstrb,
    output logic                       done,
    output logic                       misaligned
);

    state_e      state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic        done_q, done_d;
    logic        misal_q, misal_d;

    logic [7:0]  shift_strb;
    logic [63:0] shift_data;
    logic        req_fire;
    logic        req_known;
    logic        req_misal;
    logic        req_fault;

    store_lane_shift u_lane_shift (
        .op_i    (req_op),
        .off_i   (req_addr[1:0]),
        .data_i  (req_data),
        .strb_o  (shift_strb),
        .wdata_o (shift_data)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign req_fire  = req_valid & req_ready;
    assign req_known = op_known(req_op);
    assign req_misal = op_misaligned(req_op, req_addr[1:0]);

`ifdef RV_STORE_SPLIT_EN
    // Upper-word half of a crossing store, replayed in ISSUE2.
    logic [3:0]  hi_strb_q, hi_strb_d;
    logic [31:0] hi_data_q, hi_data_d;
    logic        unused_misal;

    assign req_fault    = 1'b0;
    assign unused_misal = req_misal;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_strb_q <= 4'b0000;
            hi_data_q <= 32'h0000_0000;
        end else begin
            hi_strb_q <= hi_strb_d;
            hi_data_q <= hi_data_d;
        end
    end
`else
    logic unused_hi;

    assign req_fault = req_misal;
    assign unused_hi = ^{shift_strb[7:4], shift_data[63:32]};
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
            mem_wstrb_q <= 4'b0000;
            done_q      <= 1'b0;
            misal_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            done_q      <= done_d;
            misal_q     <= misal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire && req_known && !req_fault) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
`ifdef RV_STORE_SPLIT_EN
                    state_d = (hi_strb_q != 4'b0000) ? ST_ISSUE2 : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
`ifdef RV_STORE_SPLIT_EN
            ST_ISSUE2: begin
                if (mem_ready) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        done_d      = 1'b0;
        misal_d     = 1'b0;
`ifdef RV_STORE_SPLIT_EN
        hi_strb_d   = hi_strb_q;
        hi_data_d   = hi_data_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_fire) begin
                    if (req_known && !req_fault) begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_wstrb_d = shift_strb[3:0];
                        mem_wdata_d = shift_data[31:0];
`ifdef RV_STORE_SPLIT_EN
                        hi_strb_d   = shift_strb[7:4];
                        hi_data_d   = shift_data[63:32];
`endif
                    end else begin
                        // Unknown ops finish silently; known ops here are alignment faults.
                        done_d  = 1'b1;
                        misal_d = req_known;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
`ifdef RV_STORE_SPLIT_EN
                    if (hi_strb_q != 4'b0000) begin
                        mem_addr_d  = mem_addr_q + 32'd4;
                        mem_wstrb_d = hi_strb_q;
                        mem_wdata_d = hi_data_q;
                    end else begin
                        mem_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end
`else
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
`endif
                end
            end
`ifdef RV_STORE_SPLIT_EN
            ST_ISSUE2: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    done_d      = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign done       = done_q;
    assign misaligned = misal_q;

endmodule

// File: tb/tb_store_alignment_unit.sv
// Scoreboard bench for store_alignment_unit; expectations follow RV_STORE_SPLIT_EN when defined.
module tb_store_alignment_unit;
    import store_alignment_unit_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } wr_t;

    localparam store_op_t BAD_OP = '1;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    store_op_t   req_op = '0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_data = 32'h0;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        done;
    logic        misaligned;

    int checks = 0;
    int fails  = 0;

    wr_t wr_q[$];
    bit  dn_q[$];

    always #5 clk = ~clk;

    store_alignment_unit dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .done       (done),
        .misaligned (misaligned)
    );

    // Monitor: every accepted write and every done pulse is matched against the scoreboard.
    always begin
        @(negedge clk);
        #1;
        if (mem_valid && mem_ready) begin
            checks++;
            if (wr_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%h strb=%b data=%h, want no write",
                         mem_addr, mem_wstrb, mem_wdata);
            end else begin
                wr_t e;
                e = wr_q.pop_front();
                if (mem_addr !== e.addr || mem_wstrb !== e.strb || mem_wdata !== e.data) begin
                    fails++;
                    $display("FAIL write: got addr=%h strb=%b data=%h, want addr=%h strb=%b data=%h",
                             mem_addr, mem_wstrb, mem_wdata, e.addr, e.strb, e.data);
                end
            end
        end
        if (done) begin
            checks++;
            if (dn_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done=1 misaligned=%b, want no done", misaligned);
            end else begin
                bit em;
                em = dn_q.pop_front();
                if (misaligned !== em) begin
                    fails++;
                    $display("FAIL done_misaligned: got %b, want %b", misaligned, em);
                end
            end
        end else if (misaligned) begin
            checks++;
            fails++;
            $display("FAIL misaligned_without_done: got misaligned=1 done=0, want misaligned=0");
        end
    end

    // Reference model built lane by lane from the store size, independent of the shift formulation.
    function automatic void model(input store_op_t op, input logic [31:0] a, input logic [31:0] d);
        int          sz;
        int          off;
        logic [7:0]  s8;
        logic [63:0] d64;
        logic [31:0] base;
        off = int'(a[1:0]);
        if (op == OP_SB)      sz = 1;
        else if (op == OP_SH) sz = 2;
        else if (op == OP_SW) sz = 4;
        else                  sz = 0;
        if (sz == 0) begin
            dn_q.push_back(1'b0);
            return;
        end
`ifndef RV_STORE_SPLIT_EN
        if ((a % sz) != 0) begin
            dn_q.push_back(1'b1);
            return;
        end
`endif
        s8  = 8'h00;
        d64 = 64'h0;
        for (int j = 0; j < sz; j++) begin
            s8[off + j]            = 1'b1;
            d64[8*(off + j) +: 8]  = d[8*j +: 8];
        end
        base = {a[31:2], 2'b00};
        wr_q.push_back('{base, s8[3:0], d64[31:0]});
        if (s8[7:4] != 4'b0000) begin
            wr_q.push_back('{base + 32'd4, s8[7:4], d64[63:32]});
        end
        dn_q.push_back(1'b0);
    endfunction

    // Called at a negedge; returns at the negedge where the request has been accepted.
    task automatic send(input store_op_t op, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = a;
        req_data  = d;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_op    = '0;
        req_addr  = 32'h0;
        req_data  = 32'h0;
    endtask

    // Counts cycles from the current negedge (1) until done is seen; 0 means the bound expired.
    task automatic wait_done(input bit rnd_ready, output int cyc);
        cyc = 1;
        forever begin
            if (rnd_ready) mem_ready = 1'($urandom_range(0, 1));
            if (done) return;
            if (cyc >= 60) begin
                cyc = 0;
                return;
            end
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        #1 resetn = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || done !== 1'b0 || misaligned !== 1'b0 || mem_addr !== 32'h0 ||
            mem_wdata !== 32'h0 || mem_wstrb !== 4'b0000 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_state: got valid=%b done=%b mis=%b addr=%h data=%h strb=%b ready=%b, want 0/0/0/0/0/0/1",
                     mem_valid, done, misaligned, mem_addr, mem_wdata, mem_wstrb, req_ready);
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: got ready=%b valid=%b, want ready=1 valid=0", req_ready, mem_valid);
        end
    endtask

    task automatic test_sb_single();
        int cyc;
        wr_q.push_back('{32'h0000_1000, 4'b0100, 32'h00DD_0000});
        dn_q.push_back(1'b0);
        send(OP_SB, 32'h0000_1002, 32'hAABB_CCDD);
        mem_ready = 1'b1;
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL sb_done_cycle: got %0d, want 2", cyc);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL sb_ready_at_done: got %b, want 1", req_ready);
        end
    endtask

    task automatic test_sw_wait();
        int cyc;
        wr_q.push_back('{32'h0000_2000, 4'b1111, 32'h1234_5678});
        dn_q.push_back(1'b0);
        mem_ready = 1'b0;
        send(OP_SW, 32'h0000_2000, 32'h1234_5678);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_addr !== 32'h0000_2000 || mem_wstrb !== 4'b1111 ||
                mem_wdata !== 32'h1234_5678 || done !== 1'b0) begin
                fails++;
                $display("FAIL sw_wait_hold cycle %0d: got valid=%b addr=%h strb=%b data=%h done=%b, want 1/00002000/1111/12345678/0",
                         k, mem_valid, mem_addr, mem_wstrb, mem_wdata, done);
            end
            if (k < 4) @(negedge clk);
        end
        mem_ready = 1'b1;
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 2) begin
            fails++;
            $display("FAIL sw_done_after_ready: got %0d, want 2", cyc);
        end
    endtask

    task automatic test_sh_cross();
        int cyc;
        int want_cyc;
        bit want_valid;
`ifdef RV_STORE_SPLIT_EN
        wr_q.push_back('{32'h0000_3000, 4'b1000, 32'hEF00_0000});
        wr_q.push_back('{32'h0000_3004, 4'b0001, 32'h0000_00BE});
        dn_q.push_back(1'b0);
        want_cyc   = 3;
        want_valid = 1'b1;
`else
        dn_q.push_back(1'b1);
        want_cyc   = 1;
        want_valid = 1'b0;
`endif
        mem_ready = 1'b1;
        send(OP_SH, 32'h0000_3003, 32'h0000_BEEF);
        checks++;
        if (mem_valid !== want_valid) begin
            fails++;
            $display("FAIL sh_cross_valid: got %b, want %b", mem_valid, want_valid);
        end
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== want_cyc) begin
            fails++;
            $display("FAIL sh_cross_done_cycle: got %0d, want %0d", cyc, want_cyc);
        end
    endtask

    task automatic test_sh_odd_inword();
        int cyc;
        int want_cyc;
`ifdef RV_STORE_SPLIT_EN
        wr_q.push_back('{32'h0000_5000, 4'b0110, 32'h0012_3400});
        dn_q.push_back(1'b0);
        want_cyc = 2;
`else
        dn_q.push_back(1'b1);
        want_cyc = 1;
`endif
        mem_ready = 1'b1;
        send(OP_SH, 32'h0000_5001, 32'h9999_1234);
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== want_cyc) begin
            fails++;
            $display("FAIL sh_odd_done_cycle: got %0d, want %0d", cyc, want_cyc);
        end
    endtask

    task automatic test_sw_wrap();
        int cyc;
        int want_cyc;
`ifdef RV_STORE_SPLIT_EN
        wr_q.push_back('{32'hFFFF_FFFC, 4'b1100, 32'h3344_0000});
        wr_q.push_back('{32'h0000_0000, 4'b0011, 32'h0000_1122});
        dn_q.push_back(1'b0);
        want_cyc = 3;
`else
        dn_q.push_back(1'b1);
        want_cyc = 1;
`endif
        mem_ready = 1'b1;
        send(OP_SW, 32'hFFFF_FFFE, 32'h1122_3344);
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== want_cyc) begin
            fails++;
            $display("FAIL sw_wrap_done_cycle: got %0d, want %0d", cyc, want_cyc);
        end
    endtask

    task automatic test_bad_op();
        int cyc;
        dn_q.push_back(1'b0);
        mem_ready = 1'b1;
        send(BAD_OP, 32'h0000_6000, 32'hDEAD_BEEF);
        checks++;
        if (mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL bad_op_valid: got %b, want 0", mem_valid);
        end
        wait_done(1'b0, cyc);
        checks++;
        if (cyc !== 1) begin
            fails++;
            $display("FAIL bad_op_done_cycle: got %0d, want 1", cyc);
        end
    endtask

    task automatic test_reset_mid();
        mem_ready = 1'b0;
        send(OP_SW, 32'h0000_4000, 32'hCAFE_F00D);
        checks++;
        if (mem_valid !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pending: got valid=%b, want 1", mem_valid);
        end
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        checks++;
        if (mem_valid !== 1'b0 || mem_wstrb !== 4'b0000 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async: got valid=%b strb=%b done=%b, want 0/0000/0", mem_valid, mem_wstrb, done);
        end
        @(negedge clk);
        resetn = 1'b1;
        mem_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b1 || mem_valid !== 1'b0 || done !== 1'b0) begin
                fails++;
                $display("FAIL reset_mid_after: got ready=%b valid=%b done=%b, want 1/0/0", req_ready, mem_valid, done);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          cyc;
        int          r;
        store_op_t   op;
        logic [31:0] a;
        logic [31:0] d;
        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 7));
            if (r == 7)               op = BAD_OP;
            else if (r % 3 == 0)      op = OP_SB;
            else if (r % 3 == 1)      op = OP_SH;
            else                      op = OP_SW;
            a = $urandom;
            if (n == 5) a = 32'hFFFF_FFFF;
            d = $urandom;
            checks++;
            if (req_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready #%0d: got %b, want 1", n, req_ready);
            end
            model(op, a, d);
            send(op, a, d);
            wait_done(1'b1, cyc);
            checks++;
            if (cyc == 0) begin
                fails++;
                $display("FAIL b2b_timeout #%0d: got no done within 60 cycles, want done", n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sb_single();
        test_sw_wait();
        test_sh_cross();
        test_sh_odd_inword();
        test_sw_wrap();
        test_bad_op();
        test_reset_mid();
        test_back_to_back();
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        checks++;
        if (wr_q.size() != 0 || dn_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d writes and %0d dones outstanding, want 0 and 0",
                     wr_q.size(), dn_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", checks, fails);
        $finish;
    end

endmodule
